// File: rtl/shift_pkg.sv
// shift_pkg: operation codes and FSM state encoding shared by the shift/rotate unit
package shift_pkg;
    localparam logic [2:0] SR_SHL  = 3'd0;
    localparam logic [2:0] SR_SHR  = 3'd1;
    localparam logic [2:0] SR_SHRA = 3'd2;
    localparam logic [2:0] SR_ROL  = 3'd3;
    localparam logic [2:0] SR_ROR  = 3'd4;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;
endpackage

// File: rtl/shift_rotate_step.sv
// shift_rotate_step: one combinational shift/rotate of s positions, reporting the last bit pushed out
module shift_rotate_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    s,
    input  logic             fill,
    output logic [WIDTH-1:0] value_out,
    output logic             bit_out
);
    logic [WIDTH-1:0] up;
    logic [WIDTH-1:0] dn;
    logic [WIDTH-1:0] up_wrap;
    logic [WIDTH-1:0] dn_wrap;
    logic [WIDTH-1:0] fill_mask;
    logic             left;
    always_comb begin
        up        = value << s;
        dn        = value >> s;
        // bits leaving one end, realigned to the other end; all zero when s == 0
        up_wrap   = value >> (WIDTH - int'(s));
        dn_wrap   = value << (WIDTH - int'(s));
        fill_mask = {WIDTH{fill}} << (WIDTH - int'(s));
        left      = (op == SR_SHL) || (op == SR_ROL);
        value_out = (op == SR_SHL)  ? up :
                    (op == SR_SHR)  ? dn :
                    (op == SR_SHRA) ? (dn | fill_mask) :
                    (op == SR_ROL)  ? (up | up_wrap) :
                    (op == SR_ROR)  ? (dn | dn_wrap) : value;
        bit_out   = left ? up_wrap[0] : dn_wrap[WIDTH-1];
    end
endmodule

// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: multi-cycle SHL/SHR/SHRA/ROL/ROR unit, STEP positions per cycle, start/done handshake
module shift_rotate_unit
    import shift_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  STEP  = 1,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AW-1:0]    amount,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);
    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic [AW-1:0]    s;
    logic [WIDTH-1:0] step_value;
    logic             step_bit;

    // rem never reaches WIDTH, so STEP only matters while it is below rem
    assign s = (int'(rem_q) < STEP) ? rem_q : AW'(STEP);

    shift_rotate_step #(
        .WIDTH(WIDTH),
        .AW   (AW)
    ) u_step (
        .value    (result_q),
        .op       (op_q),
        .s        (s),
        .fill     (fill_q),
        .value_out(step_value),
        .bit_out  (step_bit)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rem_d    = rem_q;
        fill_d   = fill_q;
        result_d = result_q;
        cout_d   = cout_q;
        if (state_q == ST_RUN) begin
            result_d = step_value;
            rem_d    = rem_q - s;
            cout_d   = step_bit;
            state_d  = (rem_q == s) ? ST_DONE : ST_RUN;
        end else if (start) begin
            op_d     = op;
            result_d = a;
            fill_d   = a[WIDTH-1];
            cout_d   = 1'b0;
            rem_d    = (op > SR_ROR) ? '0 : amount;
            state_d  = (rem_d == '0) ? ST_DONE : ST_RUN;
        end else begin
            state_d  = ST_IDLE;
        end
        zero_d = result_d == '0;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            op_q     <= SR_SHL;
            rem_q    <= '0;
            fill_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            fill_q   <= fill_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

    assign ready  = state_q != ST_RUN;
    assign busy   = state_q == ST_RUN;
    assign done   = state_q == ST_DONE;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
endmodule

// File: tb/tb_shift_rotate_unit.sv
// tb_shift_rotate_unit: STEP=1 and STEP=4 units checked every cycle against a whole-shift behavioural model
module tb_shift_rotate_unit;
    import shift_pkg::*;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear  [2];
    logic         start  [2];
    logic [2:0]   op     [2];
    logic [W-1:0] a      [2];
    logic [4:0]   amount [2];
    logic         ready  [2];
    logic         busy   [2];
    logic         done   [2];
    logic [W-1:0] result [2];
    logic         cout   [2];
    logic         zero   [2];
    int           n_chk = 0;
    int           n_pass = 0;

    // model: 0 idle, 1 running, 2 done
    int           m_st   [2];
    int           m_left [2];
    logic [W-1:0] m_res  [2];
    logic [W-1:0] p_res  [2];
    logic         m_cout [2];
    logic         p_cout [2];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        shift_rotate_unit #(
            .WIDTH(W),
            .STEP (g == 0 ? 1 : 4)
        ) u_dut (
            .clock (clock),
            .clear (clear[g]),
            .start (start[g]),
            .op    (op[g]),
            .a     (a[g]),
            .amount(amount[g]),
            .ready (ready[g]),
            .busy  (busy[g]),
            .done  (done[g]),
            .result(result[g]),
            .cout  (cout[g]),
            .zero  (zero[g])
        );
    end

    // whole shift done in one go: {cout, result}
    function automatic logic [W:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input int c);
        logic signed [W-1:0] sx;
        logic [W-1:0]        r;
        logic                co;
        if (o > SR_ROR || c == 0) return {1'b0, x};
        sx = x;
        if (o == SR_SHL) r = x << c;
        else if (o == SR_SHR) r = x >> c;
        else if (o == SR_SHRA) r = sx >>> c;
        else if (o == SR_ROL) r = (x << c) | (x >> (W - c));
        else r = (x >> c) | (x << (W - c));
        co = (o == SR_SHL || o == SR_ROL) ? x[W - c] : x[c - 1];
        return {co, r};
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            int         c;
            int         n;
            int         stp;
            logic [W:0] rr;
            stp = (k == 0) ? 1 : 4;
            if (clear[k]) begin
                m_st[k]   <= 0;
                m_left[k] <= 0;
                m_res[k]  <= '0;
                m_cout[k] <= 1'b0;
            end else if (m_st[k] != 1 && start[k]) begin
                c  = (op[k] > SR_ROR) ? 0 : int'(amount[k]);
                rr = ref_op(op[k], a[k], c);
                n  = (c + stp - 1) / stp;
                p_res[k]  <= rr[W-1:0];
                p_cout[k] <= rr[W];
                m_left[k] <= n;
                if (n == 0) begin
                    m_st[k]   <= 2;
                    m_res[k]  <= rr[W-1:0];
                    m_cout[k] <= rr[W];
                end else begin
                    m_st[k]   <= 1;
                end
            end else if (m_st[k] == 1) begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) begin
                    m_st[k]   <= 2;
                    m_res[k]  <= p_res[k];
                    m_cout[k] <= p_cout[k];
                end
            end else begin
                m_st[k] <= 0;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, want %h at %0t", nm, k, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk("ready", k, W'(ready[k]), W'(m_st[k] != 1));
            chk("busy", k, W'(busy[k]), W'(m_st[k] == 1));
            chk("done", k, W'(done[k]), W'(m_st[k] == 2));
            if (m_st[k] != 1) begin
                chk("result", k, result[k], m_res[k]);
                chk("cout", k, W'(cout[k]), W'(m_cout[k]));
                chk("zero", k, W'(zero[k]), W'(m_res[k] == '0));
            end
        end
    endtask

    task automatic settle();
        int t = 0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        while ((busy[0] || busy[1]) && t < 100) begin
            tick();
            t++;
        end
        chk("settle_timeout", 0, W'(t < 100), W'(1));
        tick();
        tick();
    endtask

    task automatic run_op(input int k, input logic [2:0] o, input logic [W-1:0] x, input logic [4:0] amt,
                          input logic [W-1:0] er, input logic ec, input int el, input bit hold);
        int lat = 0;
        op[k]     = o;
        a[k]      = x;
        amount[k] = amt;
        start[k]  = 1'b1;
        do begin
            tick();
            lat++;
            if (hold) begin
                op[k]     = 3'($urandom_range(0, 7));
                a[k]      = $urandom;
                amount[k] = 5'($urandom);
            end else begin
                start[k] = 1'b0;
            end
        end while (!done[k] && lat < 200);
        chk("lit_latency", k, W'(lat), W'(el));
        chk("lit_result", k, result[k], er);
        chk("lit_cout", k, W'(cout[k]), W'(ec));
        if (hold) tick();
        start[k] = 1'b0;
        settle();
    endtask

    initial begin
        logic [W:0] rr;
        for (int k = 0; k < 2; k++) begin
            clear[k]  = 1'b1;
            start[k]  = 1'b0;
            op[k]     = SR_SHL;
            a[k]      = '0;
            amount[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_result", k, result[k], '0);
            chk("rst_zero", k, W'(zero[k]), W'(1));
            chk("rst_ready", k, W'(ready[k]), W'(1));
            chk("rst_done", k, W'(done[k]), W'(0));
            clear[k] = 1'b0;
        end
        rr = ref_op(SR_ROR, 32'h1, 1);
        chk("model_ror", 0, rr[W-1:0], 32'h8000_0000);
        rr = ref_op(SR_SHRA, 32'h8000_0000, 31);
        chk("model_shra", 0, rr[W-1:0], 32'hFFFF_FFFF);
        rr = ref_op(SR_ROL, 32'h12, 20);
        chk("model_rol", 0, rr[W-1:0], 32'h0120_0000);
        tick();

        run_op(0, SR_ROL, 32'h12, 5'd20, 32'h0120_0000, 1'b0, 21, 1'b0);
        run_op(1, SR_ROL, 32'h12, 5'd20, 32'h0120_0000, 1'b0, 6, 1'b0);
        run_op(1, SR_ROR, 32'h1, 5'd1, 32'h8000_0000, 1'b1, 2, 1'b0);
        run_op(0, SR_SHRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 32, 1'b0);
        run_op(1, SR_SHRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 9, 1'b0);
        run_op(0, SR_SHR, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 32, 1'b0);
        run_op(1, SR_SHL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1, 9, 1'b0);
        run_op(0, SR_SHL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1, 32, 1'b0);
        run_op(0, SR_SHR, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1, 1'b0);
        run_op(1, 3'd6, 32'h0000_1234, 5'd5, 32'h0000_1234, 1'b0, 1, 1'b0);
        run_op(0, SR_SHL, 32'h1, 5'd0, 32'h1, 1'b0, 1, 1'b0);
        chk("lit_zero", 0, W'(zero[0]), W'(0));
        run_op(0, SR_ROL, 32'h12, 5'd20, 32'h0120_0000, 1'b0, 21, 1'b1);
        run_op(1, SR_ROR, 32'h0000_00F0, 5'd7, 32'hE000_0001, 1'b1, 3, 1'b1);

        op[0]     = SR_ROL;
        a[0]      = 32'h12;
        amount[0] = 5'd20;
        start[0]  = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (4) tick();
        clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0;
        chk("clr_busy", 0, W'(busy[0]), W'(0));
        chk("clr_done", 0, W'(done[0]), W'(0));
        chk("clr_result", 0, result[0], '0);
        chk("clr_zero", 0, W'(zero[0]), W'(1));
        tick();
        chk("clr_no_done", 0, W'(done[0]), W'(0));
        run_op(0, SR_ROL, 32'h12, 5'd20, 32'h0120_0000, 1'b0, 21, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                int r = int'($urandom_range(0, 7));
                clear[k]  = $urandom_range(0, 59) == 0;
                start[k]  = $urandom_range(0, 2) != 0;
                op[k]     = 3'($urandom_range(0, 7));
                a[k]      = (r == 0) ? '0 : (r == 1) ? '1 : $urandom;
                amount[k] = 5'($urandom);
            end
            tick();
        end
        clear[0] = 1'b0;
        clear[1] = 1'b0;
        settle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
